// File: rtl/abm_ram_writer.sv
// AXI4 write-only slave that fills one ABM SDP RAM through its write port.
// Define ABM_WR_CLEAR_EN to build in the zero-fill clear engine (clear_req / clear_busy).
module abm_ram_writer #(
  parameter int DW = 512,
  parameter int DD = 16384
) (
  input  logic                          clk,
  input  logic                          resetn,
  output logic [$clog2(DD)-1:0]         ram_waddr,
  output logic [DW-1:0]                 ram_wdata,
  output logic [DW/8-1:0]               ram_we,
  input  logic                          clear_req,
  output logic                          clear_busy,
  output logic [2:0]                    dbg_state,
  input  logic [$clog2(DD*DW/8)-1:0]    S_AXI_AWADDR,
  input  logic                          S_AXI_AWVALID,
  input  logic [3:0]                    S_AXI_AWID,
  input  logic [7:0]                    S_AXI_AWLEN,
  input  logic [2:0]                    S_AXI_AWSIZE,
  input  logic [1:0]                    S_AXI_AWBURST,
  input  logic                          S_AXI_AWLOCK,
  input  logic [3:0]                    S_AXI_AWCACHE,
  input  logic [3:0]                    S_AXI_AWQOS,
  input  logic [2:0]                    S_AXI_AWPROT,
  output logic                          S_AXI_AWREADY,
  input  logic [DW-1:0]                 S_AXI_WDATA,
  input  logic [DW/8-1:0]               S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  input  logic                          S_AXI_WLAST,
  output logic                          S_AXI_WREADY,
  output logic [3:0]                    S_AXI_BID,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [$clog2(DD*DW/8)-1:0]    S_AXI_ARADDR,
  input  logic                          S_AXI_ARVALID,
  input  logic [3:0]                    S_AXI_ARID,
  input  logic [7:0]                    S_AXI_ARLEN,
  input  logic [2:0]                    S_AXI_ARSIZE,
  input  logic [1:0]                    S_AXI_ARBURST,
  input  logic                          S_AXI_ARLOCK,
  input  logic [3:0]                    S_AXI_ARCACHE,
  input  logic [3:0]                    S_AXI_ARQOS,
  input  logic [2:0]                    S_AXI_ARPROT,
  output logic                          S_AXI_ARREADY,
  output logic [DW-1:0]                 S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RLAST,
  output logic [3:0]                    S_AXI_RID,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY
);
  localparam int WA_W = $clog2(DD);
  localparam int BA_W = $clog2(DD*DW/8);
  localparam int SB_W = $clog2(DW/8);

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
`ifdef ABM_WR_CLEAR_EN
  localparam logic [2:0] S_CLEAR = 3'd4;
`endif

  // Handshakes: a transfer happens on a rising clk edge where VALID and READY are both high.
  // VALID never depends on READY; READY here is registered and may assert before VALID.
  logic [2:0]      state;
  logic [WA_W-1:0] addr;
  logic            clr_hold;
  logic            aw_hs;
  logic            w_hs;
  logic            b_hs;

  assign aw_hs     = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs      = S_AXI_WVALID & S_AXI_WREADY;
  assign b_hs      = S_AXI_BVALID & S_AXI_BREADY;
  assign dbg_state = state;

  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = 1'b0;
  assign S_AXI_RVALID  = 1'b0;
  assign S_AXI_RDATA   = '0;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RLAST   = 1'b0;
  assign S_AXI_RID     = 4'd0;

`ifdef ABM_WR_CLEAR_EN
  logic pending;
  logic start_clear;

  assign clr_hold    = pending | clear_req;
  assign start_clear = (state == S_IDLE) && !aw_hs && clr_hold;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pending    <= 1'b0;
      clear_busy <= 1'b0;
    end else begin
      if (start_clear) begin
        clear_busy <= 1'b1;
      end else if (state == S_CLEAR && addr == '1) begin
        clear_busy <= 1'b0;
        pending    <= 1'b0;
      end
      // Requests that cannot start a clear right now are remembered once; ignored while clearing.
      if (clear_req && state != S_CLEAR && !start_clear) pending <= 1'b1;
    end
  end
`else
  logic unused_clear;
  assign unused_clear = clear_req;
  assign clr_hold     = 1'b0;
  assign clear_busy   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= S_INIT;
      addr          <= '0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BID     <= 4'd0;
      ram_we        <= '0;
      ram_waddr     <= '0;
      ram_wdata     <= '0;
    end else begin
      ram_we <= '0;
      case (state)
        S_INIT: begin
          S_AXI_AWREADY <= 1'b1;
          state         <= S_IDLE;
        end
        S_IDLE: begin
          if (aw_hs) begin
            addr          <= S_AXI_AWADDR[BA_W-1:SB_W];
            S_AXI_BID     <= S_AXI_AWID;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b1;
            state         <= S_DATA;
          end
`ifdef ABM_WR_CLEAR_EN
          else if (clr_hold) begin
            S_AXI_AWREADY <= 1'b0;
            addr          <= '0;
            state         <= S_CLEAR;
          end
`endif
        end
        S_DATA: begin
          if (w_hs) begin
            ram_waddr <= addr;
            ram_wdata <= S_AXI_WDATA;
            ram_we    <= S_AXI_WSTRB;
            addr      <= addr + 1'b1;
            if (S_AXI_WLAST) begin
              S_AXI_WREADY <= 1'b0;
              S_AXI_BVALID <= 1'b1;
              state        <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (b_hs) begin
            S_AXI_BVALID  <= 1'b0;
            // A queued clear must win over the next AW, so keep AWREADY low into IDLE.
            S_AXI_AWREADY <= !clr_hold;
            state         <= S_IDLE;
          end
        end
`ifdef ABM_WR_CLEAR_EN
        S_CLEAR: begin
          ram_waddr <= addr;
          ram_wdata <= '0;
          ram_we    <= '1;
          addr      <= addr + 1'b1;
          if (addr == '1) begin
            S_AXI_AWREADY <= 1'b1;
            state         <= S_IDLE;
          end
        end
`endif
        default: state <= S_INIT;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, S_AXI_AWADDR[SB_W-1:0], S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST,
                       S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWQOS, S_AXI_AWPROT, S_AXI_ARADDR,
                       S_AXI_ARVALID, S_AXI_ARID, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST,
                       S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARQOS, S_AXI_ARPROT, S_AXI_RREADY};
endmodule

// File: tb/tb_abm_ram_writer.sv
// Bench for abm_ram_writer: directed and randomized AXI write bursts, clear engine
// (when ABM_WR_CLEAR_EN is defined) and mid-burst reset, checked against expected RAM writes.
`timescale 1ns/1ps
module tb_abm_ram_writer;
  localparam int DW   = 64;
  localparam int DD   = 16;
  localparam int SW   = DW/8;
  localparam int WA_W = $clog2(DD);
  localparam int BA_W = $clog2(DD*DW/8);
  localparam int W    = WA_W + DW + SW;

  logic clk, resetn, clear_req, clear_busy;
  logic [WA_W-1:0] ram_waddr;
  logic [DW-1:0]   ram_wdata;
  logic [SW-1:0]   ram_we;
  logic [2:0]      dbg_state;
  logic [BA_W-1:0] awaddr, araddr;
  logic            awvalid, awready, awlock, arvalid, arready, arlock;
  logic [3:0]      awid, awcache, awqos, arid, arcache, arqos, bid, rid;
  logic [7:0]      awlen, arlen;
  logic [2:0]      awsize, awprot, arsize, arprot;
  logic [1:0]      awburst, arburst, bresp, rresp;
  logic [DW-1:0]   wdata, rdata;
  logic [SW-1:0]   wstrb;
  logic            wvalid, wlast, wready, bvalid, bready, rlast, rvalid, rready;

  abm_ram_writer #(.DW(DW), .DD(DD)) dut (
    .clk(clk), .resetn(resetn), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .clear_req(clear_req), .clear_busy(clear_busy), .dbg_state(dbg_state),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWID(awid), .S_AXI_AWLEN(awlen),
    .S_AXI_AWSIZE(awsize), .S_AXI_AWBURST(awburst), .S_AXI_AWLOCK(awlock),
    .S_AXI_AWCACHE(awcache), .S_AXI_AWQOS(awqos), .S_AXI_AWPROT(awprot), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WLAST(wlast),
    .S_AXI_WREADY(wready), .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready), .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARID(arid),
    .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst), .S_AXI_ARLOCK(arlock),
    .S_AXI_ARCACHE(arcache), .S_AXI_ARQOS(arqos), .S_AXI_ARPROT(arprot),
    .S_AXI_ARREADY(arready), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_RID(rid), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int vectors     = 0;
  int miscompares = 0;

  // Every RAM write pulse, as the RAM would see it.
  always @(negedge clk) begin
    if (ram_we != '0) got_q.push_back({ram_waddr, ram_wdata, ram_we});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WA_W-1:0] word_of(input logic [BA_W-1:0] a, input int beat);
    return WA_W'((int'(a) / SW + beat) % DD);
  endfunction

  task automatic aw_send(input logic [BA_W-1:0] a, input logic [3:0] id);
    int n = 0;
    awaddr = a; awid = id; awlen = 8'($urandom); awsize = 3'($urandom); awburst = 2'($urandom);
    awvalid = 1'b1;
    while (!awready && n < 64) begin tick(); n++; end
    chk("aw_timeout", 128'(n < 64), 128'(1));
    tick();
    awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [DW-1:0] d, input logic [SW-1:0] s, input bit last,
                        input int gap, input logic [WA_W-1:0] wa);
    int n = 0;
    wvalid = 1'b0;
    repeat (gap) begin tick(); chk("gap_we", 128'(ram_we), 128'(0)); end
    wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
    while (!wready && n < 64) begin tick(); n++; end
    chk("w_timeout", 128'(n < 64), 128'(1));
    tick();
    wvalid = 1'b0; wlast = 1'b0;
    exp_q.push_back({wa, d, s});
  endtask

  task automatic b_resp(input logic [3:0] id, input int hold);
    int n = 0;
    bready = 1'b0;
    while (!bvalid && n < 64) begin tick(); n++; end
    chk("b_timeout", 128'(n < 64), 128'(1));
    chk("bid", 128'(bid), 128'(id));
    chk("bresp", 128'(bresp), 128'(0));
    repeat (hold) begin
      tick();
      chk("b_hold_valid", 128'(bvalid), 128'(1));
      chk("b_hold_awready", 128'(awready), 128'(0));
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("b_drop", 128'(bvalid), 128'(0));
  endtask

  task automatic burst(input logic [BA_W-1:0] a, input logic [3:0] id, input int nb,
                       input int gap_at, input int gap_n, input logic [SW-1:0] strb,
                       input bit rnd_strb, input int hold);
    aw_send(a, id);
    for (int i = 0; i < nb; i++) begin
      logic [DW-1:0] d;
      logic [SW-1:0] s;
      d = {$urandom, $urandom};
      s = rnd_strb ? SW'($urandom_range(1, (1 << SW) - 1)) : strb;
      w_beat(d, s, i == nb - 1, (i == gap_at) ? gap_n : 0, word_of(a, i));
    end
    b_resp(id, hold);
  endtask

  task automatic check_writes(input string tag);
    tick();
    chk({tag, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) chk(tag, 128'(got_q.pop_front()), 128'(exp_q.pop_front()));
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic clear_run(input string tag);
    int n = 0;
    while (!clear_busy && n < 4) begin tick(); n++; end
    n = 0;
    while (clear_busy && n < 40) begin
      chk({tag, "_awready"}, 128'(awready), 128'(0));
      tick();
      n++;
    end
    chk({tag, "_busy_len"}, 128'(n), 128'(DD));
    for (int i = 0; i < DD; i++) exp_q.push_back({WA_W'(i), {DW{1'b0}}, {SW{1'b1}}});
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_awready"}, 128'(awready), 128'(0));
    chk({tag, "_wready"}, 128'(wready), 128'(0));
    chk({tag, "_bvalid"}, 128'(bvalid), 128'(0));
    chk({tag, "_bid"}, 128'(bid), 128'(0));
    chk({tag, "_ram_we"}, 128'(ram_we), 128'(0));
    chk({tag, "_waddr"}, 128'(ram_waddr), 128'(0));
    chk({tag, "_wdata"}, 128'(ram_wdata), 128'(0));
    chk({tag, "_clear_busy"}, 128'(clear_busy), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    int n;
    resetn = 1'b0; clear_req = 1'b0;
    awaddr = '0; awvalid = 1'b0; awid = '0; awlen = '0; awsize = '0; awburst = '0; awlock = 1'b0;
    awcache = '0; awqos = '0; awprot = '0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; arid = '0; arlen = '0; arsize = '0; arburst = '0; arlock = 1'b0;
    arcache = '0; arqos = '0; arprot = '0; rready = 1'b0;
    repeat (3) tick();
    check_reset_values("reset");
    resetn = 1'b1;
    tick();
    chk("aw_after_reset", 128'(awready), 128'(1));

    // Read channel is tied off even when the master tries to read.
    arvalid = 1'b1; rready = 1'b1;
    tick();
    chk("arready", 128'(arready), 128'(0));
    chk("rvalid", 128'({rvalid, rlast, rresp, rid}), 128'(0));
    chk("rdata", 128'(rdata), 128'(0));
    arvalid = 1'b0; rready = 1'b0;

    // Single beat: write pulse one clk after the W handshake, for exactly one clk.
    d = {32'hA5A5A5A5, 32'hA5A5A5A5};
    aw_send(BA_W'('h40), 4'd5);
    w_beat(d, '1, 1'b1, 0, word_of(BA_W'('h40), 0));
    chk("t1_we", 128'(ram_we), 128'({SW{1'b1}}));
    chk("t1_waddr", 128'(ram_waddr), 128'('h40 / SW));
    chk("t1_wdata", 128'(ram_wdata), 128'(d));
    tick();
    chk("t1_we_pulse", 128'(ram_we), 128'(0));
    b_resp(4'd5, 0);
    chk("t1_awready", 128'(awready), 128'(1));
    check_writes("t1");

    // Four beats with a two-clock WVALID gap before beat 3.
    burst('0, 4'd3, 4, 2, 2, '1, 1'b0, 0);
    check_writes("t2");

    // Partial strobes and word-address wrap at the top of the RAM.
    burst(BA_W'((DD - 2) * SW), 4'd9, 3, 0, 0, SW'('h0F), 1'b0, 0);
    check_writes("t3");

    // B held off for 10 clocks.
    burst(BA_W'(3 * SW), 4'd12, 2, 1, 1, '1, 1'b0, 10);
    chk("t4_awready", 128'(awready), 128'(1));
    check_writes("t4");

    for (int k = 0; k < 12; k++) begin
      int nb;
      nb = $urandom_range(1, 6);
      burst(BA_W'($urandom_range(0, DD * SW - 1)), 4'($urandom), nb, $urandom_range(0, nb - 1),
            $urandom_range(0, 2), '0, 1'b1, $urandom_range(0, 3));
      chk("rnd_awready", 128'(awready), 128'(1));
      check_writes("rnd");
    end

`ifdef ABM_WR_CLEAR_EN
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    clear_run("clr_idle");
    check_writes("clr_idle");
    chk("clr_idle_aw_after", 128'(awready), 128'(1));

    aw_send(BA_W'(5 * SW), 4'd7);
    w_beat({$urandom, $urandom}, '1, 1'b0, 0, 4'(5));
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    w_beat({$urandom, $urandom}, '1, 1'b1, 1, 4'(6));
    chk("clr_pend_busy_early", 128'(clear_busy), 128'(0));
    b_resp(4'd7, 0);
    chk("clr_pend_busy_at_b", 128'(clear_busy), 128'(0));
    chk("clr_pend_awready", 128'(awready), 128'(0));
    clear_run("clr_pend");
    check_writes("clr_pend");
    chk("clr_pend_aw_after", 128'(awready), 128'(1));
`else
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("noclr_busy", 128'(clear_busy), 128'(0));
    chk("noclr_awready", 128'(awready), 128'(1));
    aw_send(BA_W'(5 * SW), 4'd7);
    clear_req = 1'b1;
    w_beat({$urandom, $urandom}, '1, 1'b1, 0, 4'(5));
    clear_req = 1'b0;
    b_resp(4'd7, 0);
    chk("noclr_aw_after", 128'(awready), 128'(1));
    chk("noclr_busy2", 128'(clear_busy), 128'(0));
    check_writes("noclr");
`endif

    // Reset in the middle of a four-beat burst, with beat 2 being offered.
    aw_send(BA_W'(2 * SW), 4'd11);
    w_beat({$urandom, $urandom}, '1, 1'b0, 0, 4'(2));
    wdata = {$urandom, $urandom}; wstrb = '1; wvalid = 1'b1;
    resetn = 1'b0;
    tick();
    check_reset_values("rst_mid");
    tick();
    chk("rst_mid_we2", 128'(ram_we), 128'(0));
    resetn = 1'b1;
    wvalid = 1'b0;
    n = 0;
    while (!awready && n < 2) begin tick(); n++; end
    chk("rst_release_awready", 128'(awready), 128'(1));
    check_writes("rst_mid");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
